// File: rtl/serializer_pkg.sv
// Shared constants for the encrypter array and the serializer FSM state type.
// The parallelizer uses the same values so both sides agree on packet shape.
package serializer_pkg;
  localparam int NUM_ENCRYPTERS       = 4;
  localparam int ENCRYPTER_WIDTH      = 32;
  localparam int ENCRYPTER_QSPI_COUNT = ENCRYPTER_WIDTH / 4;
  localparam int NUM_ENCRYPTERS_REG   = $clog2(NUM_ENCRYPTERS);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;
endpackage

// File: rtl/serializer_nibble_shifter.sv
// Output shift register for one packet: presents the MSB nibble and counts
// the nibbles still to go. A load takes priority over an accept.
module serializer_nibble_shifter #(
  parameter int WIDTH = serializer_pkg::ENCRYPTER_WIDTH,
  parameter int COUNT = WIDTH / 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             accept,
  output logic [3:0]       data,
  output logic             last
);
  localparam int CNT_W = $clog2(COUNT + 1);

  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] nib_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg   <= '0;
      nib_cnt_reg <= '0;
    end else if (load) begin
      shift_reg   <= load_data;
      nib_cnt_reg <= CNT_W'(COUNT);
    end else if (accept) begin
      shift_reg   <= shift_reg << 4;
      nib_cnt_reg <= nib_cnt_reg - CNT_W'(1);
    end
  end

  assign data = shift_reg[WIDTH-1 -: 4];
  assign last = (nib_cnt_reg == CNT_W'(1));
endmodule

// File: rtl/serializer.sv
// Collects finished packets from the encrypters in strict round-robin order
// and streams them to the host as QSPI nibbles through a one-packet hold buffer.
module serializer #(
  parameter int NUM_ENCRYPTERS  = serializer_pkg::NUM_ENCRYPTERS,
  parameter int ENCRYPTER_WIDTH = serializer_pkg::ENCRYPTER_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_ENCRYPTERS*ENCRYPTER_WIDTH-1:0] encrypters_result,
  input  logic [NUM_ENCRYPTERS-1:0]             encrypters_done,
  output logic [NUM_ENCRYPTERS-1:0]             encrypters_ack,
  output logic [3:0]                            qspi_data_out,
  output logic                                  qspi_valid,
  output logic                                  qspi_last,
  input  logic                                  qspi_host_ready,
  output logic                                  busy
);
  import serializer_pkg::*;

  localparam int QSPI_COUNT = ENCRYPTER_WIDTH / 4;
  localparam int IDX_W      = (NUM_ENCRYPTERS > 1) ? $clog2(NUM_ENCRYPTERS) : 1;

  ser_state_t                state_reg, state_next;
  logic [IDX_W-1:0]          idx_reg;
  logic [ENCRYPTER_WIDTH-1:0] hold_reg;
  logic                      hold_valid_reg;
  logic [NUM_ENCRYPTERS-1:0] ack_reg, ack_next;
  logic                      capture, accept, load, shifter_last;
  logic [ENCRYPTER_WIDTH-1:0] result_arr [NUM_ENCRYPTERS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENCRYPTERS; gi++) begin : g_result
      assign result_arr[gi] = encrypters_result[gi*ENCRYPTER_WIDTH +: ENCRYPTER_WIDTH];
    end
  endgenerate

  // A pending ack blocks capture so the encrypter has a cycle to drop done.
  assign capture = !hold_valid_reg && encrypters_done[idx_reg] && (ack_reg == '0);
  assign accept  = (state_reg == SHIFT) && qspi_host_ready;

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (hold_valid_reg) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (accept && shifter_last) begin
          if (hold_valid_reg) load = 1'b1;
          else                state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ack_next = '0;
    if (capture) ack_next[idx_reg] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      hold_reg       <= '0;
      hold_valid_reg <= 1'b0;
      ack_reg        <= '0;
    end else begin
      state_reg <= state_next;
      ack_reg   <= ack_next;
      // capture and load are mutually exclusive: capture needs an empty hold
      if (capture) begin
        hold_reg       <= result_arr[idx_reg];
        hold_valid_reg <= 1'b1;
        idx_reg        <= (idx_reg == IDX_W'(NUM_ENCRYPTERS - 1)) ? '0 : idx_reg + IDX_W'(1);
      end else if (load) begin
        hold_valid_reg <= 1'b0;
      end
    end
  end

  serializer_nibble_shifter #(
    .WIDTH (ENCRYPTER_WIDTH),
    .COUNT (QSPI_COUNT)
  ) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (hold_reg),
    .accept    (accept),
    .data      (qspi_data_out),
    .last      (shifter_last)
  );

  assign qspi_valid     = (state_reg == SHIFT);
  assign qspi_last      = qspi_valid && shifter_last;
  assign encrypters_ack = ack_reg;
  assign busy           = (state_reg == SHIFT) || hold_valid_reg;
endmodule

// File: tb/tb_serializer.sv
// Bench for serializer: directed latency/reset/ordering checks, then random
// traffic checked by a scoreboard fed from a packet-order reference model.
module tb_serializer;
  localparam int N = 4;
  localparam int W = 32;
  localparam int Q = W / 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N*W-1:0] encrypters_result;
  logic [N-1:0]   encrypters_done;
  logic [N-1:0]   encrypters_ack;
  logic [3:0]     qspi_data_out;
  logic           qspi_valid;
  logic           qspi_last;
  logic           qspi_host_ready;
  logic           busy;

  serializer #(.NUM_ENCRYPTERS(N), .ENCRYPTER_WIDTH(W)) dut (
    .clk               (clk),
    .reset             (reset),
    .encrypters_result (encrypters_result),
    .encrypters_done   (encrypters_done),
    .encrypters_ack    (encrypters_ack),
    .qspi_data_out     (qspi_data_out),
    .qspi_valid        (qspi_valid),
    .qspi_last         (qspi_last),
    .qspi_host_ready   (qspi_host_ready),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: packet k goes to encrypter k%N and leaves k-th in the stream.
  logic [4:0]   exp_q[$];
  logic [W-1:0] pkt_mem [128];
  int           n_pkts = 0;
  int           next_k [N];
  int           dly [N];
  int           exp_idx = 0;
  logic         sb_en = 1'b0;
  logic         stall_prev = 1'b0;
  logic [5:0]   stall_snap = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_pkt();
    logic [W-1:0] v;
    v = $urandom;
    pkt_mem[n_pkts] = v;
    for (int n = 0; n < Q; n++) exp_q.push_back({(n == Q - 1), v[W-1-4*n -: 4]});
    n_pkts++;
  endtask

  // Encrypter and host behaviour for one cycle, applied #1 after the edge.
  task automatic drive(input int max_delay, input int ready_pct);
    if (encrypters_ack != '0) begin
      chk("ack_round_robin", 32'(encrypters_ack), 32'(1 << exp_idx));
      exp_idx = (exp_idx + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (encrypters_ack[i]) begin
        encrypters_done[i] = 1'b0;
        dly[i] = $urandom_range(0, max_delay);
      end else if (!encrypters_done[i] && next_k[i] < n_pkts) begin
        if (dly[i] == 0) begin
          encrypters_done[i] = 1'b1;
          encrypters_result[i*W +: W] = pkt_mem[next_k[i]];
          next_k[i] += N;
        end else begin
          dly[i]--;
        end
      end
    end
    qspi_host_ready = ($urandom_range(0, 99) < ready_pct);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    encrypters_done = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Scoreboard monitor: pops one expected nibble per host accept.
  always @(negedge clk) begin
    if (sb_en) begin
      if (stall_prev)
        chk("stall_stable", 32'({qspi_valid, qspi_last, qspi_data_out}), 32'(stall_snap));
      if (qspi_valid && qspi_host_ready) begin
        if (exp_q.size() == 0) chk("sb_unexpected_nibble", 32'(exp_q.size()), 32'd1);
        else chk("nibble", 32'({qspi_last, qspi_data_out}), 32'(exp_q.pop_front()));
      end
      stall_prev = qspi_valid && !qspi_host_ready;
      stall_snap = {qspi_valid, qspi_last, qspi_data_out};
    end
  end

  initial begin
    logic [W-1:0] v;
    logic [N-1:0] ack_seq [3];
    int na, cyc, gaps;
    logic seen_valid;

    encrypters_result = '0;
    encrypters_done   = '0;
    qspi_host_ready   = 1'b1;
    for (int i = 0; i < N; i++) begin next_k[i] = i; dly[i] = 0; end
    do_reset();
    chk("reset_valid", 32'(qspi_valid), 32'd0);
    chk("reset_last",  32'(qspi_last), 32'd0);
    chk("reset_data",  32'(qspi_data_out), 32'd0);
    chk("reset_busy",  32'(busy), 32'd0);
    chk("reset_ack",   32'(encrypters_ack), 32'd0);

    // Single packet: ack in t+1, nibbles in t+2..t+9.
    v = 32'h1234ABCD;
    encrypters_result[0 +: W] = v;
    encrypters_done[0] = 1'b1;
    @(posedge clk); #1;
    chk("single_ack", 32'(encrypters_ack), 32'd1);
    chk("single_valid_early", 32'(qspi_valid), 32'd0);
    encrypters_done[0] = 1'b0;
    for (int n = 0; n < Q; n++) begin
      @(posedge clk); #1;
      chk("single_valid", 32'(qspi_valid), 32'd1);
      chk("single_nibble", 32'(qspi_data_out), 32'(v[W-1-4*n -: 4]));
      chk("single_last", 32'(qspi_last), 32'(n == Q - 1));
      chk("single_ack_once", 32'(encrypters_ack), 32'd0);
    end
    @(posedge clk); #1;
    chk("single_idle_valid", 32'(qspi_valid), 32'd0);
    chk("single_idle_busy", 32'(busy), 32'd0);

    // Reset on nibble 3 of the next packet (encrypter 1), then idx restarts at 0.
    encrypters_result[1*W +: W] = 32'hCAFEF00D;
    encrypters_done[1] = 1'b1;
    @(posedge clk); #1;
    chk("mid_ack1", 32'(encrypters_ack), 32'd2);
    encrypters_done[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", 32'(qspi_valid), 32'd0);
    chk("mid_rst_last", 32'(qspi_last), 32'd0);
    chk("mid_rst_data", 32'(qspi_data_out), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    v = 32'h5A5A0FF0;
    encrypters_result[0 +: W] = v;
    encrypters_done[0] = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ack0", 32'(encrypters_ack), 32'd1);
    encrypters_done[0] = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_first", 32'(qspi_data_out), 32'h5);
    repeat (Q) @(posedge clk);

    // Ordering: done[1], done[2] ignored until done[0] arrives.
    do_reset();
    encrypters_done[1] = 1'b1;
    encrypters_done[2] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("order_wait_ack", 32'(encrypters_ack), 32'd0);
    end
    encrypters_done[0] = 1'b1;
    na = 0;
    for (int c = 0; c < 40 && na < 3; c++) begin
      @(posedge clk); #1;
      if (encrypters_ack != '0) begin
        ack_seq[na] = encrypters_ack;
        na++;
        encrypters_done = encrypters_done & ~encrypters_ack;
      end
    end
    chk("order_ack_count", 32'(na), 32'd3);
    chk("order_first", 32'(ack_seq[0]), 32'd1);
    chk("order_second", 32'(ack_seq[1]), 32'd2);
    chk("order_third", 32'(ack_seq[2]), 32'd4);

    // Random traffic with host stalls and random encrypter delays.
    do_reset();
    exp_idx = 0;
    for (int k = 0; k < 40; k++) add_pkt();
    sb_en = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 4000) begin
      @(posedge clk); #1;
      drive(12, 70);
      cyc++;
    end
    chk("random_drained", 32'(exp_q.size()), 32'd0);

    // Back-to-back: host always ready, done immediately -> no bubbles.
    for (int k = 0; k < 12; k++) add_pkt();
    gaps = 0;
    seen_valid = 1'b0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 2000) begin
      @(posedge clk); #1;
      drive(0, 100);
      if (seen_valid && !qspi_valid && exp_q.size() != 0) gaps++;
      if (qspi_valid) seen_valid = 1'b1;
      cyc++;
    end
    chk("b2b_drained", 32'(exp_q.size()), 32'd0);
    chk("b2b_no_bubble", 32'(gaps), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("final_busy", 32'(busy), 32'd0);
    sb_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serializer.md
# serializer

Output-side counterpart of the input parallelizer. It collects finished packets from the encrypter array in strict round-robin order, starting at encrypter 0. This is the same order in which packets were dispatched, so the output stream keeps the input order. Each packet is streamed to the host as QSPI nibbles, MSB nibble first. A one-packet holding buffer lets the next packet be captured while the current one shifts out, so back-to-back packets leave with no bubble.

## Interface
Parameters:
- NUM_ENCRYPTERS, 4: number of encrypters; index register width is $clog2(NUM_ENCRYPTERS).
- ENCRYPTER_WIDTH, 32: packet width in bits; must be a multiple of 4 and ≥ 8.
- QSPI_COUNT, ENCRYPTER_WIDTH/4: nibbles per packet (derived, not overridden).

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- encrypters_result  in  NUM_ENCRYPTERS*ENCRYPTER_WIDTH  flattened result buses; encrypter i occupies bits [i*W +: W].
- encrypters_done  in  NUM_ENCRYPTERS  level; result i is valid and stable while high.
- encrypters_ack  out  NUM_ENCRYPTERS  one-hot, one-cycle pulse; result i has been captured.
- qspi_data_out  out  4  current nibble.
- qspi_valid  out  1  qspi_data_out is valid.
- qspi_last  out  1  current nibble is the last of its packet.
- qspi_host_ready  in  1  host accepts a nibble in any cycle where qspi_valid && qspi_host_ready.
- busy  out  1  state==SHIFT or hold_valid.

## Operation
Registers:
- idx: next encrypter to collect.
- hold_reg, hold_valid: one-packet holding buffer.
- shift_reg: output shift register.
- nib_cnt: nibbles remaining in the current packet.
- state: IDLE or SHIFT.
- ack_r: registered ack.

Capture:
- Condition: !hold_valid && encrypters_done[idx] && ack_r==0.
- On capture: hold_reg <= result[idx]; hold_valid <= 1; ack_r <= one-hot(idx); idx <= idx+1, wrapping NUM_ENCRYPTERS-1 → 0.
- Capture is blocked in any cycle with ack_r != 0. This gives the encrypter one cycle to drop done and prevents a double capture when NUM_ENCRYPTERS==1.
- done on any encrypter other than idx is ignored until idx reaches it. There is no skipping.

State machine:
- IDLE, when hold_valid: shift_reg <= hold_reg; hold_valid <= 0; nib_cnt <= QSPI_COUNT; go to SHIFT.
- SHIFT, on each host accept: shift_reg <= shift_reg << 4; nib_cnt <= nib_cnt-1.
- SHIFT, accept with nib_cnt==1 and hold_valid: reload from hold exactly as in IDLE and stay in SHIFT (no bubble).
- SHIFT, accept with nib_cnt==1 and !hold_valid: go to IDLE.
- A hold→shift move and a capture never occur in the same cycle, because capture requires hold_valid==0 at the edge.

Outputs:
- qspi_valid = (state==SHIFT).
- qspi_data_out = shift_reg[W-1 -: 4].
- qspi_last = (state==SHIFT && nib_cnt==1).
- All are combinational from registers; no combinational path from inputs.

## Timing
- Reset values: state=IDLE, idx=0, hold_valid=0, nib_cnt=0, shift_reg=0, ack_r=0. Outputs after reset: encrypters_ack=0, qspi_valid=0, qspi_last=0, qspi_data_out=0, busy=0.
- Reset mid-packet drops the current and held packets. No ack is re-issued. idx restarts at 0.
- Latency: done[idx] seen in cycle t with hold empty → ack pulse and hold_valid in t+1 → first nibble valid in t+2.
- Host stall: qspi_host_ready=0 holds qspi_data_out, qspi_valid and qspi_last stable.
- Steady state with the host always ready: one nibble per cycle, continuous across packets. Each packet is acked while the previous one shifts, as long as done arrives at least 2 cycles before that packet ends.
- done dropping before ack is an encrypter protocol violation; the behaviour is unspecified.

## Structure
- The shared constants header holds NUM_ENCRYPTERS, ENCRYPTER_WIDTH, ENCRYPTER_QSPI_COUNT and NUM_ENCRYPTERS_REG. These are the same values the parallelizer uses, and the parameters default from them.
- Sub-module nibble_shifter: shift_reg, nib_cnt, load/accept inputs, data/last outputs.
- The top level contains the round-robin capture, the hold buffer and the FSM.

## Test plan
- Single packet: reset; done[0]=1 with result0=0x1234ABCD; host always ready → ack[0] pulses in cycle t+1 only; nibbles 1,2,3,4,A,B,C,D in cycles t+2..t+9; qspi_last only on D; then IDLE, busy=0.
- Ordering: done[2] and done[1] high first, done[0] raised 5 cycles later → nothing captured until done[0]; output order is packet 0, 1, 2; idx wraps 3 → 0 after packet 3.
- Back-to-back: all four done high with distinct results → 32 consecutive valid nibbles with no gap; the acks are spaced by at least 2 cycles.
- Host stall: drop qspi_host_ready for 3 cycles on nibble 5 → nibble 5 is held stable for 3 cycles; the rest of the stream is unchanged.
- Hold full: host stalled and a second packet held → done[2] high is not acked until the hold→shift move occurs.
- Reset mid-stream: assert reset on nibble 3 → next cycle all outputs are 0; a new done[0] is collected normally.
